// File: rtl/vend_ctrl.sv
// Vending-machine transaction FSM: accumulates coin credit, vends the selected
// item, then pays change back one greedy coin per cycle.
module vend_ctrl #(
  parameter int CW         = 8,
  parameter int MAX_CREDIT = 200,
  parameter int PRICE0     = 50,
  parameter int PRICE1     = 75,
  parameter int PRICE2     = 100,
  parameter int PRICE3     = 125
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin5_p,
  input  logic          coin10_p,
  input  logic          coin25_p,
  input  logic          sel_p,
  input  logic          cancel_p,
  input  logic [1:0]    item_sel,
  output logic [CW-1:0] credit,
  output logic          dispense,
  output logic [1:0]    item_out,
  output logic          deny,
  output logic          coin_reject,
  output logic          ret25,
  output logic          ret10,
  output logic          ret5,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_credit;
  logic [1:0]    r_item;
  logic          r_dispense, r_deny, r_coin_reject;
  logic          r_ret25, r_ret10, r_ret5, r_busy;

  logic          w_coin_any, w_coin_multi, w_fit, w_afford, w_coin_rej;
  logic [CW:0]   w_coin_val, w_sum;
  logic [CW-1:0] w_price, w_credit_add, w_after_buy, w_chg_step;

  assign w_coin_any   = coin5_p | coin10_p | coin25_p;
  assign w_coin_multi = (coin5_p & coin10_p) | (coin5_p & coin25_p) | (coin10_p & coin25_p);

  // Only the highest-value coin is a candidate; all others are rejected.
  always_comb begin
    w_coin_val = '0;
    if (coin25_p)      w_coin_val = (CW+1)'(25);
    else if (coin10_p) w_coin_val = (CW+1)'(10);
    else if (coin5_p)  w_coin_val = (CW+1)'(5);
  end

  always_comb begin
    w_price = '0;
    case (item_sel)
      2'd0:    w_price = CW'(PRICE0);
      2'd1:    w_price = CW'(PRICE1);
      2'd2:    w_price = CW'(PRICE2);
      default: w_price = CW'(PRICE3);
    endcase
  end

  always_comb begin
    w_chg_step = CW'(5);
    if (r_credit >= CW'(25))      w_chg_step = CW'(25);
    else if (r_credit >= CW'(10)) w_chg_step = CW'(10);
  end

  assign w_sum        = {1'b0, r_credit} + w_coin_val;
  assign w_fit        = (w_sum <= (CW+1)'(MAX_CREDIT));
  assign w_credit_add = w_fit ? w_sum[CW-1:0] : r_credit;
  assign w_coin_rej   = w_coin_any & (w_coin_multi | ~w_fit);
  // Affordability uses pre-coin credit; a same-cycle coin still lands in credit.
  assign w_afford     = (r_credit >= w_price);
  assign w_after_buy  = w_credit_add - w_price;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_item        <= '0;
      r_dispense    <= 1'b0;
      r_deny        <= 1'b0;
      r_coin_reject <= 1'b0;
      r_ret25       <= 1'b0;
      r_ret10       <= 1'b0;
      r_ret5        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_dispense    <= 1'b0;
      r_deny        <= 1'b0;
      r_coin_reject <= 1'b0;
      r_ret25       <= 1'b0;
      r_ret10       <= 1'b0;
      r_ret5        <= 1'b0;
      case (r_state)
        S_IDLE, S_CREDIT: begin
          if (cancel_p && (r_state == S_CREDIT)) begin
            r_coin_reject <= w_coin_any;
            r_state       <= S_CHANGE;
            r_busy        <= 1'b1;
          end else begin
            r_coin_reject <= w_coin_rej;
            if (sel_p && w_afford) begin
              r_credit   <= w_after_buy;
              r_item     <= item_sel;
              r_dispense <= 1'b1;
              r_state    <= S_VEND;
              r_busy     <= 1'b1;
            end else begin
              r_deny   <= sel_p;
              r_credit <= w_credit_add;
              r_state  <= (w_credit_add != '0) ? S_CREDIT : S_IDLE;
              r_busy   <= 1'b0;
            end
          end
        end
        S_VEND: begin
          r_coin_reject <= w_coin_any;
          r_state       <= (r_credit != '0) ? S_CHANGE : S_IDLE;
          r_busy        <= (r_credit != '0);
        end
        S_CHANGE: begin
          r_coin_reject <= w_coin_any;
          r_ret25       <= (w_chg_step == CW'(25));
          r_ret10       <= (w_chg_step == CW'(10));
          r_ret5        <= (w_chg_step == CW'(5));
          r_credit      <= r_credit - w_chg_step;
          if (r_credit == w_chg_step) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign credit      = r_credit;
  assign item_out    = r_item;
  assign dispense    = r_dispense;
  assign deny        = r_deny;
  assign coin_reject = r_coin_reject;
  assign ret25       = r_ret25;
  assign ret10       = r_ret10;
  assign ret5        = r_ret5;
  assign busy        = r_busy;

endmodule
